// File: rtl/teststorage.sv
// 64 x 32 flip-flop memory exercise block; the addressed word is shown one byte at a time on LED.
// Mem_Write inverts the addressed word in place, and reset reloads the whole array.
module teststorage (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Mem_Addr,
  input  logic [1:0] CS,
  input  logic       Mem_Write,
  output logic [7:0] LED
);

  localparam int unsigned Depth = 64;

  logic [31:0] mem_q [Depth];
  logic [31:0] rd_word;
  logic [7:0]  led_d, led_q;

  // Byte k of word i holds (4*i + k) mod 256.
  function automatic logic [31:0] init_word(input int unsigned idx);
    logic [7:0] base;
    base = 8'(idx << 2);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  always_comb begin
    rd_word = mem_q[Mem_Addr];
    led_d   = rd_word[{CS, 3'b000} +: 8];
  end

  // LED samples rd_word before the write lands, so the write edge still shows the old byte.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[6'(i)] <= init_word(i);
      end
      led_q <= '0;
    end else begin
      if (Mem_Write) begin
        mem_q[Mem_Addr] <= ~rd_word;
      end
      led_q <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_teststorage.sv
// Self-checking bench for teststorage: directed steps plus a model-driven random stretch,
// with expected LED bytes queued at drive time and compared after each rising edge.
module tb_teststorage;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Mem_Addr;
  logic [1:0] CS;
  logic       Mem_Write;
  logic [7:0] LED;

  logic [7:0]  exp_q [$];
  string       tag_q [$];
  logic [31:0] model [64];
  int          total = 0;
  int          bad   = 0;

  teststorage dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Mem_Addr  (Mem_Addr),
    .CS        (CS),
    .Mem_Write (Mem_Write),
    .LED       (LED)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] pattern_word(input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'((4 * i + k) % 256);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = pattern_word(i);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exp < 0 takes the expected byte from the bench model; otherwise exp is the literal value.
  task automatic step(input logic [5:0] a, input logic [1:0] c, input logic w, input int exp,
                      input string tag);
    logic [7:0] e;
    @(negedge Clk);
    Mem_Addr  = a;
    CS        = c;
    Mem_Write = w;
    e = (exp < 0) ? model[a][c*8 +: 8] : 8'(exp);
    if (w) model[a] = ~model[a];
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clk);
    #1;
    check(tag_q.pop_front(), LED, exp_q.pop_front());
  endtask

  task automatic reset_pulse();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("reset_pulse", LED, 8'h00);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    Mem_Addr  = '0;
    CS        = '0;
    Mem_Write = 1'b0;
    model_reset();
    #12;
    check("during_reset", LED, 8'h00);
    Mem_Write = 1'b1;
    @(posedge Clk);
    #1;
    check("reset_blocks_write", LED, 8'h00);
    @(negedge Clk);
    Mem_Write = 1'b0;
    Reset     = 1'b0;

    for (int c = 0; c < 4; c++) begin
      step(6'd0, 2'(c), 1'b0, c, "addr0_lane");
      step(6'd0, 2'(c), 1'b0, c, "addr0_lane_hold");
    end
    for (int c = 0; c < 4; c++) step(6'd1, 2'(c), 1'b0, 4 + c, "addr1_lane");
    step(6'd63, 2'd3, 1'b0, 'hFF, "addr63_lane3");
    step(6'd63, 2'd0, 1'b0, 'hFC, "addr63_lane0");

    step(6'd1, 2'd2, 1'b1, 'h06, "write_edge_old");
    step(6'd1, 2'd2, 1'b0, 'hF9, "write_visible");
    for (int c = 0; c < 4; c++) step(6'd0, 2'(c), 1'b0, c, "neighbour_untouched");
    step(6'd1, 2'd0, 1'b0, 'hFB, "write_other_lane");
    step(6'd1, 2'd2, 1'b1, 'hF9, "rewrite_edge_old");
    step(6'd1, 2'd2, 1'b0, 'h06, "rewrite_restored");

    // Three held write edges leave the word inverted.
    for (int m = 0; m < 3; m++) step(6'd7, 2'd1, 1'b1, -1, "held_write");
    step(6'd7, 2'd1, 1'b0, 'hE2, "held_write_odd");

    for (int n = 0; n < 60; n++) begin
      step(6'($urandom_range(63)), 2'($urandom_range(3)), ($urandom_range(2) == 0), -1,
           "random");
    end

    reset_pulse();
    step(6'd7, 2'd1, 1'b0, 'h1D, "reset_reload");

    step(6'd5, 2'd0, 1'b1, 'h14, "w5_edge_old");
    step(6'd5, 2'd0, 1'b0, 'hEB, "w5_visible");
    // Reset arrives between edges while a write is pending.
    Mem_Write = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_led", LED, 8'h00);
    model_reset();
    @(posedge Clk);
    #1;
    check("reset_mid_write", LED, 8'h00);
    @(negedge Clk);
    Reset     = 1'b0;
    Mem_Write = 1'b0;
    step(6'd5, 2'd0, 1'b0, 'h14, "w5_after_reset");
    step(6'd5, 2'd1, 1'b0, 'h15, "w5_lane1_after_reset");
    step(6'd63, 2'd2, 1'b0, 'hFE, "addr63_lane2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
